// File: rtl/uart_ctrl_if.sv
// Peripheral bus seen by uart_ctrl: one single-beat request at a time,
// completed by a one-cycle ack that carries read data and the error flag.
interface uart_ctrl_if;
    logic        rd_en;
    logic        wr_en;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        ack;
    logic        bus_err;

    modport master (output rd_en, wr_en, addr, wr_data, input rd_data, ack, bus_err);
    modport slave  (input rd_en, wr_en, addr, wr_data, output rd_data, ack, bus_err);
endinterface

// File: rtl/uart_ctrl.sv
// Register bank and FIFO strobe sequencer in front of uart_phy.
// Define UART_CTRL_BUS_ERROR_EN to report unmapped/misaligned/RO-write accesses on bus_err.
module uart_ctrl #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic                          clock,
    input  logic                          reset,
    uart_ctrl_if.slave                    bus,
    output logic                          txen,
    output logic                          rxen,
    output logic                          nstop,
    output logic [15:0]                   div,
    output logic [$clog2(FIFO_DEPTH)-1:0] txcnt,
    output logic [$clog2(FIFO_DEPTH)-1:0] rxcnt,
    output logic [7:0]                    tx_fifo_wr_data,
    output logic                          tx_fifo_wr_en,
    output logic                          rx_fifo_rd_en,
    input  logic [7:0]                    rx_fifo_rd_data,
    input  logic                          tx_fifo_full,
    input  logic                          rx_fifo_empty,
    input  logic                          tx_fifo_less_than_watermark,
    input  logic                          rx_fifo_greater_than_watermark,
    output logic                          interrupt
);
    localparam int CW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] A_TXDATA = 3'd0;
    localparam logic [2:0] A_RXDATA = 3'd1;
    localparam logic [2:0] A_TXCTRL = 3'd2;
    localparam logic [2:0] A_RXCTRL = 3'd3;
    localparam logic [2:0] A_IE     = 3'd4;
    localparam logic [2:0] A_IP     = 3'd5;
    localparam logic [2:0] A_DIV    = 3'd6;
    localparam logic [2:0] A_NONE   = 3'd7;

    typedef enum logic [1:0] {IDLE, OP, ACK} state_t;

    typedef struct packed {
        logic        wr;
        logic [2:0]  word;
        logic        misaligned;
        logic [31:0] data;
    } req_t;

    state_t      state_q, state_d;
    req_t        req_q;
    logic [1:0]  ie, ip;
    logic [31:0] rd_data_q, rd_mux;
    logic        bad;

    assign ip = {rx_fifo_greater_than_watermark, tx_fifo_less_than_watermark};

    // Bad accesses are dropped silently in both builds; only reporting differs.
    assign bad = req_q.misaligned || (req_q.word == A_NONE) || (req_q.wr && req_q.word == A_IP);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        tx_fifo_wr_en = 1'b0;
        rx_fifo_rd_en = 1'b0;
        case (state_q)
            IDLE: if (bus.wr_en || bus.rd_en) state_d = OP;
            OP: begin
                state_d       = ACK;
                tx_fifo_wr_en = req_q.wr && !bad && req_q.word == A_TXDATA && !tx_fifo_full;
                rx_fifo_rd_en = !req_q.wr && !bad && req_q.word == A_RXDATA && !rx_fifo_empty;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (req_q.word)
            A_TXDATA: rd_mux[31] = tx_fifo_full;
            A_RXDATA: rd_mux = rx_fifo_empty ? 32'h8000_0000 : {24'b0, rx_fifo_rd_data};
            A_TXCTRL: begin
                rd_mux[0]     = txen;
                rd_mux[1]     = nstop;
                rd_mux[16+:CW] = txcnt;
            end
            A_RXCTRL: begin
                rd_mux[0]     = rxen;
                rd_mux[16+:CW] = rxcnt;
            end
            A_IE:    rd_mux[1:0]  = ie;
            A_IP:    rd_mux[1:0]  = ip;
            A_DIV:   rd_mux[15:0] = div;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_q     <= '0;
            rd_data_q <= '0;
            txen      <= 1'b0;
            rxen      <= 1'b0;
            nstop     <= 1'b0;
            txcnt     <= '0;
            rxcnt     <= '0;
            ie        <= '0;
            div       <= DIV_RESET;
            interrupt <= 1'b0;
        end else begin
            interrupt <= |(ie & ip);
            if (state_q == IDLE && (bus.wr_en || bus.rd_en)) begin
                req_q.wr         <= bus.wr_en;
                req_q.word       <= bus.addr[4:2];
                req_q.misaligned <= |bus.addr[1:0];
                req_q.data       <= bus.wr_data;
            end
            if (state_q == OP) begin
                rd_data_q <= (req_q.wr || bad) ? 32'h0 : rd_mux;
                if (req_q.wr && !bad) begin
                    case (req_q.word)
                        A_TXCTRL: begin
                            txen  <= req_q.data[0];
                            nstop <= req_q.data[1];
                            txcnt <= req_q.data[16+:CW];
                        end
                        A_RXCTRL: begin
                            rxen  <= req_q.data[0];
                            rxcnt <= req_q.data[16+:CW];
                        end
                        A_IE:    ie  <= req_q.data[1:0];
                        A_DIV:   div <= req_q.data[15:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    assign tx_fifo_wr_data = req_q.data[7:0];
    assign bus.rd_data     = rd_data_q;
    assign bus.ack         = (state_q == ACK);

`ifdef UART_CTRL_BUS_ERROR_EN
    logic err_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset)              err_q <= 1'b0;
        else if (state_q == OP) err_q <= bad;
    end
    assign bus.bus_err = bus.ack && err_q;
`else
    assign bus.bus_err = 1'b0;
`endif

    // Upper write-data bits map to no field.
    logic unused_ok;
    assign unused_ok = ^req_q.data[31:16+CW];
endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl: reset state, register access timing,
// FIFO strobes, interrupt, bad-access handling and mid-transaction reset.
module tb_uart_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       txen, rxen, nstop, tx_fifo_wr_en, rx_fifo_rd_en, interrupt;
    logic [15:0] div;
    logic [2:0] txcnt, rxcnt;
    logic [7:0] tx_fifo_wr_data;
    logic [7:0] rx_fifo_rd_data = 8'h00;
    logic       tx_fifo_full = 1'b0, rx_fifo_empty = 1'b1;
    logic       tx_lt_wm = 1'b0, rx_gt_wm = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    uart_ctrl_if bus ();

    uart_ctrl #(.FIFO_DEPTH(8), .DIV_RESET(16'd434)) dut (
        .clock                          (clock),
        .reset                          (reset),
        .bus                            (bus),
        .txen                           (txen),
        .rxen                           (rxen),
        .nstop                          (nstop),
        .div                            (div),
        .txcnt                          (txcnt),
        .rxcnt                          (rxcnt),
        .tx_fifo_wr_data                (tx_fifo_wr_data),
        .tx_fifo_wr_en                  (tx_fifo_wr_en),
        .rx_fifo_rd_en                  (rx_fifo_rd_en),
        .rx_fifo_rd_data                (rx_fifo_rd_data),
        .tx_fifo_full                   (tx_fifo_full),
        .rx_fifo_empty                  (rx_fifo_empty),
        .tx_fifo_less_than_watermark    (tx_lt_wm),
        .rx_fifo_greater_than_watermark (rx_gt_wm),
        .interrupt                      (interrupt)
    );

    always #5 clock = ~clock;

`ifdef UART_CTRL_BUS_ERROR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus transaction; observes the OP cycle and the ACK cycle at negedges.
    task automatic xact(input logic wr, input logic rd, input logic [4:0] a, input logic [31:0] d,
                        output logic [31:0] rdat, output logic err, output logic ack_op,
                        output logic ack_ok, output logic txs, output logic [7:0] txd,
                        output logic rxs, output logic stb_late, output logic txen_op);
        @(negedge clock);
        bus.wr_en = wr; bus.rd_en = rd; bus.addr = a; bus.wr_data = d;
        @(negedge clock);
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        ack_op  = bus.ack;
        txs     = tx_fifo_wr_en;
        txd     = tx_fifo_wr_data;
        rxs     = rx_fifo_rd_en;
        txen_op = txen;
        @(negedge clock);
        ack_ok   = bus.ack;
        rdat     = bus.rd_data;
        err      = bus.bus_err;
        stb_late = tx_fifo_wr_en | rx_fifo_rd_en;
        @(posedge clock);
    endtask

    logic [31:0] rdat;
    logic [7:0]  txd;
    logic        err, ack_op, ack_ok, txs, rxs, late, txen_op;

    initial begin
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.wr_data = '0;
        repeat (2) @(negedge clock);
        chk("rst_ack", bus.ack, 0);
        chk("rst_err", bus.bus_err, 0);
        chk("rst_rdata", bus.rd_data, 0);
        chk("rst_cfg", {txen, rxen, nstop, txcnt, rxcnt}, 0);
        chk("rst_div", div, 434);
        chk("rst_stb", {tx_fifo_wr_en, rx_fifo_rd_en, tx_fifo_wr_data}, 0);
        chk("rst_irq", interrupt, 0);
        reset = 1'b0;

        xact(0, 1, 5'h18, 0, rdat, err, ack_op, ack_ok, txs, txd, rxs, late, txen_op);
        chk("div_rd", rdat, 434);
        chk("div_ack_op", ack_op, 0);
        chk("div_ack", ack_ok, 1);
        xact(0, 1, 5'h08, 0, rdat, err, ack_op, ack_ok, txs, txd, rxs, late, txen_op);
        chk("txctrl_rst_rd", rdat, 0);

        xact(1, 0, 5'h08, 32'h0003_0003, rdat, err, ack_op, ack_ok, txs, txd, rxs, late, txen_op);
        chk("txctrl_op_txen", txen_op, 0);
        chk("txctrl_ack", ack_ok, 1);
        chk("txctrl_cfg", {txen, nstop, txcnt}, {2'b11, 3'd3});
        xact(0, 1, 5'h08, 0, rdat, err, ack_op, ack_ok, txs, txd, rxs, late, txen_op);
        chk("txctrl_rb", rdat, 32'h0003_0003);

        xact(1, 0, 5'h00, 32'h0000_00A5, rdat, err, ack_op, ack_ok, txs, txd, rxs, late, txen_op);
        chk("push_stb", txs, 1);
        chk("push_data", txd, 8'hA5);
        chk("push_late", late, 0);
        tx_fifo_full = 1'b1;
        xact(1, 0, 5'h00, 32'h0000_005A, rdat, err, ack_op, ack_ok, txs, txd, rxs, late, txen_op);
        chk("full_stb", txs, 0);
        chk("full_ack", ack_ok, 1);
        xact(0, 1, 5'h00, 0, rdat, err, ack_op, ack_ok, txs, txd, rxs, late, txen_op);
        chk("txdata_rd_full", rdat, 32'h8000_0000);
        tx_fifo_full = 1'b0;

        rx_fifo_rd_data = 8'h3C; rx_fifo_empty = 1'b0;
        xact(0, 1, 5'h04, 0, rdat, err, ack_op, ack_ok, txs, txd, rxs, late, txen_op);
        chk("pop_data", rdat, 32'h0000_003C);
        chk("pop_stb", rxs, 1);
        chk("pop_late", late, 0);
        rx_fifo_empty = 1'b1;
        xact(0, 1, 5'h04, 0, rdat, err, ack_op, ack_ok, txs, txd, rxs, late, txen_op);
        chk("empty_data", rdat, 32'h8000_0000);
        chk("empty_stb", rxs, 0);

        xact(1, 0, 5'h10, 32'h2, rdat, err, ack_op, ack_ok, txs, txd, rxs, late, txen_op);
        @(negedge clock);
        chk("irq_idle", interrupt, 0);
        rx_gt_wm = 1'b1;
        #1 chk("irq_not_yet", interrupt, 0);
        @(negedge clock);
        chk("irq_rise", interrupt, 1);
        xact(0, 1, 5'h14, 0, rdat, err, ack_op, ack_ok, txs, txd, rxs, late, txen_op);
        chk("ip_rd", rdat, 32'h2);
        xact(1, 0, 5'h10, 32'h0, rdat, err, ack_op, ack_ok, txs, txd, rxs, late, txen_op);
        @(negedge clock);
        chk("irq_fall", interrupt, 0);
        rx_gt_wm = 1'b0;

        xact(0, 1, 5'h1C, 0, rdat, err, ack_op, ack_ok, txs, txd, rxs, late, txen_op);
        chk("unmapped_rd", rdat, 0);
        chk("unmapped_err", err, ERR_EXP);
        chk("unmapped_ack", ack_ok, 1);
        xact(0, 1, 5'h02, 0, rdat, err, ack_op, ack_ok, txs, txd, rxs, late, txen_op);
        chk("misal_rd", rdat, 0);
        chk("misal_err", err, ERR_EXP);
        xact(1, 0, 5'h14, 32'h3, rdat, err, ack_op, ack_ok, txs, txd, rxs, late, txen_op);
        chk("ip_wr_err", err, ERR_EXP);
        xact(1, 0, 5'h19, 32'h5, rdat, err, ack_op, ack_ok, txs, txd, rxs, late, txen_op);
        chk("misal_wr_div", div, 434);
        xact(1, 0, 5'h01, 32'h77, rdat, err, ack_op, ack_ok, txs, txd, rxs, late, txen_op);
        chk("misal_wr_push", txs, 0);
        xact(1, 0, 5'h18, 32'h1234, rdat, err, ack_op, ack_ok, txs, txd, rxs, late, txen_op);
        chk("div_wr", div, 16'h1234);
        chk("good_err", err, 0);

        xact(1, 1, 5'h0C, 32'h0005_0001, rdat, err, ack_op, ack_ok, txs, txd, rxs, late, txen_op);
        chk("both_rxcfg", {rxen, rxcnt}, {1'b1, 3'd5});
        chk("both_rdata", rdat, 0);

        // Abort a push in its strobe cycle.
        @(negedge clock);
        bus.wr_en = 1'b1; bus.addr = 5'h00; bus.wr_data = 32'h11;
        @(negedge clock);
        bus.wr_en = 1'b0;
        chk("abort_pre_stb", tx_fifo_wr_en, 1);
        reset = 1'b1;
        #1 chk("abort_stb", tx_fifo_wr_en, 0);
        @(negedge clock);
        chk("abort_ack", bus.ack, 0);
        chk("abort_cfg", {txen, rxen, div}, {2'b00, 16'd434});
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("abort_idle", {bus.ack, tx_fifo_wr_en, rx_fifo_rd_en}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
